// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples the synchronized line at bit centres.
// A stop bit sampled low raises frame_err_o and waits for the line to return high.
module uart_rx #(
  parameter int CLKS_PER_BIT = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_i,
  output logic [7:0] d_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int N  = CLKS_PER_BIT;
  localparam int H  = N / 2;
  localparam int TW = $clog2(N) + 1;

  localparam logic [TW-1:0] TIMER_FULL = TW'(N);
  localparam logic [TW-1:0] TIMER_HALF = TW'(H);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shift, shift_n;
  logic [7:0]      d_n;
  logic            valid_n, ferr_n;
  logic            rx_meta, rxs;
  logic            sample;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      timer       <= TIMER_FULL;
      bit_idx     <= 3'd0;
      shift       <= 8'h00;
      d_o         <= 8'h00;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      d_o         <= d_n;
      valid_o     <= valid_n;
      frame_err_o <= ferr_n;
    end
  end

  assign sample = (timer == TIMER_ONE);
  assign busy_o = (state != IDLE);

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    d_n       = d_o;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          timer_n = TIMER_HALF;
        end
      end
      // A start bit that is high again at its centre was only a glitch.
      START: begin
        if (sample) begin
          timer_n   = TIMER_FULL;
          bit_idx_n = 3'd0;
          state_n   = rxs ? IDLE : DATA;
        end else begin
          timer_n = timer - TIMER_ONE;
        end
      end
      DATA: begin
        if (sample) begin
          shift_n[bit_idx] = rxs;
          timer_n          = TIMER_FULL;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          timer_n = timer - TIMER_ONE;
        end
      end
      STOP: begin
        if (sample) begin
          timer_n = TIMER_FULL;
          if (rxs) begin
            d_n     = shift;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end else begin
          timer_n = timer - TIMER_ONE;
        end
      end
      BREAK: begin
        if (rxs) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: serial frames are driven from
// byte-level tasks and pulses are checked against expected bytes and arrival times.
module tb_uart_rx;

  localparam int N = 20;
  localparam int H = N / 2;
  // Arrival of valid_o/frame_err_o relative to the cycle the start bit is driven:
  // 2 synchronizer cycles, the detecting edge, then H + 9N bit-timer edges.
  localparam int LATENCY = 3 + H + 9 * N;

  logic       clk;
  logic       resetn;
  logic       rx_i;
  logic [7:0] d_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] got_d[$];
  int         got_c[$];
  logic       got_b[$];
  int         err_c[$];
  int         both_cnt = 0;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rx_i        (rx_i),
    .d_o         (d_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse logger: every high cycle is logged, so a stretched pulse shows up twice.
  always @(negedge clk) begin
    if (valid_o) begin
      got_d.push_back(d_o);
      got_c.push_back(cyc);
      got_b.push_back(busy_o);
    end
    if (frame_err_o) err_c.push_back(cyc);
    if (valid_o && frame_err_o) both_cnt++;
  end

  task automatic clear_logs();
    got_d.delete();
    got_c.delete();
    got_b.delete();
    err_c.delete();
    both_cnt = 0;
  endtask

  // Drives one 8N1 frame starting at the current negedge; returns the start cycle.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, output int start);
    start = cyc;
    rx_i = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (N) @(negedge clk);
    end
    rx_i = stop_bit;
    repeat (N) @(negedge clk);
  endtask

  task automatic test_reset();
    rx_i   = 1'b1;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({d_o, valid_o, frame_err_o, busy_o} !== 11'h000) begin
      errors++;
      $display("[TB] FAIL reset_async got d=%h v=%b e=%b b=%b exp 00 0 0 0", d_o, valid_o, frame_err_o, busy_o);
    end
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({d_o, valid_o, frame_err_o, busy_o} !== 11'h000) begin
      errors++;
      $display("[TB] FAIL reset_idle got d=%h v=%b e=%b b=%b exp 00 0 0 0", d_o, valid_o, frame_err_o, busy_o);
    end
  endtask

  task automatic test_single();
    int s;
    clear_logs();
    applyStimulus(8'hA5, 1'b1, s);
    repeat (10) @(negedge clk);
    checks++;
    if (got_d.size() != 1 || got_d[0] !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL single_data got %0d pulses d=%h exp 1 pulse d=a5", got_d.size(), d_o);
    end else begin
      checks++;
      if (got_c[0] != s + LATENCY) begin
        errors++;
        $display("[TB] FAIL single_time got %0d exp %0d", got_c[0] - s, LATENCY);
      end
      checks++;
      if (got_b[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL single_busy got %b exp 0", got_b[0]);
      end
    end
    checks++;
    if (err_c.size() != 0) begin
      errors++;
      $display("[TB] FAIL single_ferr got %0d exp 0", err_c.size());
    end
  endtask

  task automatic test_glitch();
    int s;
    clear_logs();
    s = cyc;
    rx_i = 1'b0;
    repeat (5) @(negedge clk);
    rx_i = 1'b1;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL glitch_busy_hi got %b exp 1", busy_o);
    end
    repeat (s + 20 - cyc) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL glitch_busy_lo got %b exp 0", busy_o);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (got_d.size() != 0 || err_c.size() != 0 || d_o !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL glitch_quiet got v=%0d e=%0d d=%h exp 0 0 a5", got_d.size(), err_c.size(), d_o);
    end
  endtask

  task automatic test_frame_err();
    int s;
    int r;
    clear_logs();
    applyStimulus(8'h3C, 1'b0, s);
    repeat (50) @(negedge clk);
    r = cyc;
    rx_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL break_busy_hi got %b exp 1", busy_o);
    end
    repeat (r + 4 - cyc) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL break_busy_lo got %b exp 0", busy_o);
    end
    checks++;
    if (err_c.size() != 1 || err_c[0] != s + LATENCY) begin
      errors++;
      $display("[TB] FAIL ferr_pulse got %0d pulses first@%0d exp 1 @%0d", err_c.size(),
               (err_c.size() > 0) ? err_c[0] - s : -1, LATENCY);
    end
    checks++;
    if (got_d.size() != 0 || d_o !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL ferr_data got v=%0d d=%h exp 0 a5", got_d.size(), d_o);
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    int s1;
    clear_logs();
    applyStimulus(8'h00, 1'b1, s0);
    applyStimulus(8'hFF, 1'b1, s1);
    repeat (10) @(negedge clk);
    checks++;
    if (got_d.size() != 2) begin
      errors++;
      $display("[TB] FAIL b2b_count got %0d exp 2", got_d.size());
    end else begin
      checks++;
      if (got_d[0] !== 8'h00 || got_d[1] !== 8'hFF) begin
        errors++;
        $display("[TB] FAIL b2b_data got %h %h exp 00 ff", got_d[0], got_d[1]);
      end
      checks++;
      if (got_c[0] != s0 + LATENCY || got_c[1] != s1 + LATENCY) begin
        errors++;
        $display("[TB] FAIL b2b_time got %0d %0d exp %0d", got_c[0] - s0, got_c[1] - s1, LATENCY);
      end
    end
    checks++;
    if (err_c.size() != 0 || both_cnt != 0) begin
      errors++;
      $display("[TB] FAIL b2b_ferr got %0d exp 0", err_c.size());
    end
  endtask

  task automatic test_loopback();
    int s;
    int exp_c[$];
    clear_logs();
    for (int v = 0; v < 256; v++) begin
      applyStimulus(v[7:0], 1'b1, s);
      exp_c.push_back(s + LATENCY);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (got_d.size() != 256) begin
      errors++;
      $display("[TB] FAIL loop_count got %0d exp 256", got_d.size());
    end else begin
      for (int v = 0; v < 256; v++) begin
        checks++;
        if (got_d[v] !== v[7:0] || got_c[v] != exp_c[v]) begin
          errors++;
          $display("[TB] FAIL loop_byte%0d got %h@%0d exp %h@%0d", v, got_d[v], got_c[v], v[7:0], exp_c[v]);
        end
      end
    end
    checks++;
    if (err_c.size() != 0 || both_cnt != 0) begin
      errors++;
      $display("[TB] FAIL loop_ferr got %0d exp 0", err_c.size());
    end
  endtask

  task automatic test_reset_midframe();
    int s;
    logic [7:0] b;
    b = 8'h81;
    clear_logs();
    rx_i = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_i = b[i];
      repeat (N) @(negedge clk);
    end
    rx_i = b[4];
    repeat (H) @(negedge clk);
    #3 resetn = 1'b0;
    #1;
    checks++;
    if ({d_o, valid_o, frame_err_o, busy_o} !== 11'h000) begin
      errors++;
      $display("[TB] FAIL midreset_clear got d=%h v=%b e=%b b=%b exp 00 0 0 0", d_o, valid_o, frame_err_o, busy_o);
    end
    rx_i = 1'b1;
    repeat (30) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    applyStimulus(8'h5A, 1'b1, s);
    repeat (10) @(negedge clk);
    checks++;
    if (got_d.size() != 1 || got_d[0] !== 8'h5A || got_c[0] != s + LATENCY) begin
      errors++;
      $display("[TB] FAIL midreset_next got %0d pulses d=%h exp 1 pulse d=5a", got_d.size(), d_o);
    end
    checks++;
    if (err_c.size() != 0) begin
      errors++;
      $display("[TB] FAIL midreset_ferr got %0d exp 0", err_c.size());
    end
  endtask

  // Random bytes, idle gaps and short start-bit glitches against a queue model.
  task automatic test_random();
    int s;
    logic [7:0] b;
    logic [7:0] exp_d[$];
    int exp_c[$];
    clear_logs();
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        rx_i = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        rx_i = 1'b1;
        repeat (25) @(negedge clk);
      end
      repeat ($urandom_range(0, 40)) @(negedge clk);
      applyStimulus(b, 1'b1, s);
      exp_d.push_back(b);
      exp_c.push_back(s + LATENCY);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (got_d.size() != exp_d.size()) begin
      errors++;
      $display("[TB] FAIL rand_count got %0d exp %0d", got_d.size(), exp_d.size());
    end else begin
      for (int i = 0; i < exp_d.size(); i++) begin
        checks++;
        if (got_d[i] !== exp_d[i] || got_c[i] != exp_c[i]) begin
          errors++;
          $display("[TB] FAIL rand_frame%0d got %h@%0d exp %h@%0d", i, got_d[i], got_c[i], exp_d[i], exp_c[i]);
        end
      end
    end
    checks++;
    if (err_c.size() != 0 || both_cnt != 0) begin
      errors++;
      $display("[TB] FAIL rand_ferr got %0d exp 0", err_c.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    repeat (10) @(negedge clk);
    test_back_to_back();
    test_loopback();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 20: clock cycles per bit period (N); legal range N >= 4.
REQ-002 Derived constant H = N/2 (integer division): half-bit delay to the start-bit centre.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 resetn  input  1  reset, asynchronous and active-low; clk and resetn are the only clock and reset.
REQ-005 rx_i  input  1  asynchronous serial line; idles high; frame is 8N1, LSB first.
REQ-006 d_o  output  8  last byte received without error.
REQ-007 valid_o  output  1  one-cycle pulse; d_o has just been updated.
REQ-008 frame_err_o  output  1  one-cycle pulse; stop bit was sampled low.
REQ-009 busy_o  output  1  high while a frame is in progress or a break is being waited out.

Function
REQ-010 rx_i SHALL pass through a 2-flop synchronizer (both flops reset to 1); all logic uses only the synchronized value (rxs).
REQ-011 States SHALL be IDLE, START, DATA, STOP and BREAK; busy_o = (state != IDLE).
REQ-012 A bit timer SHALL decrement once per clk; a bit is "sampled" at the edge where timer == 1.
REQ-013 IDLE: when rxs == 0, go to START at edge t0 and load timer = H; otherwise hold.
REQ-014 START: at the edge t0+H, sample rxs.
  - If rxs == 0: go to DATA, load timer = N, clear bit index.
  - If rxs == 1 (glitch): go to IDLE with no output pulse.
REQ-015 DATA: bit k (k = 0..7) SHALL be sampled at edge t0+H+(k+1)*N into shift-register bit k; timer reloads to N after each sample.
REQ-016 DATA: after bit 7 is sampled, go to STOP with timer = N.
REQ-017 STOP: at edge t0+H+9N, sample rxs.
  - If rxs == 1: d_o <= shift register and valid_o = 1 for exactly one cycle (registered at this edge); go to IDLE.
  - If rxs == 0: frame_err_o = 1 for exactly one cycle; d_o unchanged; go to BREAK.
REQ-018 BREAK: hold until rxs == 1, then go to IDLE; no pulses are generated while in BREAK.
REQ-019 valid_o and frame_err_o SHALL never be high in the same cycle.
REQ-020 A falling edge arriving in the same edge that returns the FSM to IDLE SHALL be detected no later than the following edge, so back-to-back frames with a one-bit stop period are received.
REQ-021 rx_i activity in DATA and STOP outside the sample edges SHALL have no effect.
REQ-022 Timer width SHALL be $clog2(N)+1 bits; it never underflows (it is reloaded at expiry).
REQ-023 The timer SHALL use modular counting only: no division, and no arithmetic wider than the timer.

Reset
REQ-024 While resetn is low, asynchronously and independent of clk:
  - state = IDLE; timer = N; bit index = 0; shift register = 0.
  - d_o = 8'h00; valid_o = 0; frame_err_o = 0; busy_o = 0; synchronizer flops = 1.
REQ-025 When reset is asserted mid-frame, the partial frame SHALL be discarded with no pulse.
REQ-026 After reset is released, the first falling edge on rxs SHALL start a new frame.

Verification (N = 20, H = 10)
REQ-027 Frame 0xA5 with a valid stop bit -> d_o = 8'hA5; valid_o high exactly 1 cycle, at t0+190; frame_err_o stays 0; busy_o falls the same cycle.
REQ-028 rx_i low for 5 cycles, then high -> no valid_o or frame_err_o; busy_o high about 10 cycles then 0; d_o unchanged.
REQ-029 After 0xA5, send 0x3C with stop bit low, hold rx_i low 50 cycles, then release -> frame_err_o pulses once at t0+190; d_o stays 8'hA5; busy_o stays high until 2 cycles after rx_i rises.
REQ-030 Frames 0x00 then 0xFF back-to-back (stop bit exactly 20 cycles) -> two valid_o pulses carrying 8'h00 then 8'hFF; no errors.
REQ-031 resetn pulsed low during data bit 4 of 0x81, then a clean 0x5A frame -> immediate async clear of all outputs; no pulse for 0x81; next valid_o with d_o = 8'h5A.
REQ-032 Loopback from the team's uart_tx (same N) for all 256 byte values -> 256 valid_o pulses, in order, with d_o matching each byte; zero frame_err_o pulses.
